// File: rtl/mips_instr_encoder_pkg.sv
// Shared MIPS encoding constants, request op-class codes and encoder result type
// for the IM-image builder.
package mips_instr_encoder_pkg;

  localparam int CNT_W = 11;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  // ALU / branch selects shared with the decoder side
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_OR  = 2'd2,
    ALU_LUI = 2'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    REQ_NOP  = 4'd0,
    REQ_ADDU = 4'd1,
    REQ_SUBU = 4'd2,
    REQ_ORI  = 4'd3,
    REQ_LW   = 4'd4,
    REQ_SW   = 4'd5,
    REQ_BEQ  = 4'd6,
    REQ_LUI  = 4'd7,
    REQ_JAL  = 4'd8,
    REQ_JR   = 4'd9
  } req_op_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

endpackage

// File: rtl/mips_instr_encoder_instr_fifo.sv
// Synchronous FIFO holding encoded instruction words between the request side
// and the IM write port. DEPTH must be a power of two (pointers wrap naturally).
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers/count, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic instruction requests into MIPS words and streams them, with
// sequential byte addresses, into the instruction-memory write port.
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int          IM_WORDS   = 1024,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [10:0] issued_cnt,
  output logic [10:0] written_cnt,
  output logic        err,
  output logic        done
);

  localparam int                CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  IM_WORDS_C = CNT_W'(IM_WORDS);

  function automatic enc_t encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    enc_t e;
    // NOTE: every field gets a default before the case so no path leaves a
    // value unassigned; in an always_comb the same omission infers a latch.
    e.legal = 1'b1;
    e.word  = '0;
    case (req_op_e'(op))
      REQ_NOP:  e.word = 32'h0;
      REQ_ADDU: e.word = {OP_SPECIAL, rs, rt, rd, 5'h0, FN_ADDU};
      REQ_SUBU: e.word = {OP_SPECIAL, rs, rt, rd, 5'h0, FN_SUBU};
      REQ_ORI:  e.word = {OP_ORI, rs, rt, imm};
      REQ_LW:   e.word = {OP_LW, rs, rt, imm};
      REQ_SW:   e.word = {OP_SW, rs, rt, imm};
      REQ_BEQ:  e.word = {OP_BEQ, rs, rt, imm};
      REQ_LUI:  e.word = {OP_LUI, 5'h0, rt, imm};
      REQ_JAL:  e.word = {OP_JAL, target};
      REQ_JR:   e.word = {OP_SPECIAL, rs, 15'h0, FN_JR};
      default:  e.legal = 1'b0;
    endcase
    return e;
  endfunction

  logic [CNT_W-1:0] r_issued_cnt;
  logic [CNT_W-1:0] r_written_cnt;
  logic             r_err;

  enc_t             w_enc;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;

  assign w_enc = encode(req_op, req_rs, req_rt, req_rd, req_imm, req_target);

  // Ready looks only at registered state, never at out_ready.
  assign req_ready = !reset && (w_count < CW'(FIFO_DEPTH)) && (r_issued_cnt < IM_WORDS_C);
  assign w_accept  = req_valid && req_ready;
  assign w_push    = w_accept && w_enc.legal && !w_full;
  assign w_pop     = out_valid && out_ready;

  instr_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_enc.word),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_issued_cnt  <= '0;
      r_written_cnt <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_push)                  r_issued_cnt  <= r_issued_cnt + CNT_W'(1);
      if (w_pop)                   r_written_cnt <= r_written_cnt + CNT_W'(1);
      if (w_accept && !w_enc.legal) r_err        <= 1'b1;
    end
  end

  assign out_valid   = !w_empty;
  assign out_data    = w_empty ? 32'h0 : w_head;
  assign out_addr    = BASE_ADDR + (32'(r_written_cnt) << 2);
  assign issued_cnt  = r_issued_cnt;
  assign written_cnt = r_written_cnt;
  assign err         = r_err;
  assign done        = (r_written_cnt == IM_WORDS_C);

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: queue-based reference model with
// a per-cycle compare process, directed scenarios and randomized traffic.
module tb_mips_instr_encoder;

  localparam int          IM    = 8;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [4:0]  req_rs = '0;
  logic [4:0]  req_rt = '0;
  logic [4:0]  req_rd = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [10:0] issued_cnt;
  logic [10:0] written_cnt;
  logic        err;
  logic        done;

  mips_instr_encoder #(
    .BASE_ADDR  (BASE),
    .IM_WORDS   (IM),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .req_rd      (req_rd),
    .req_imm     (req_imm),
    .req_target  (req_target),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .issued_cnt  (issued_cnt),
    .written_cnt (written_cnt),
    .err         (err),
    .done        (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  int          m_issued = 0;
  int          m_written = 0;
  bit          m_err = 1'b0;

  function automatic logic [31:0] model_enc(input logic [3:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [15:0] imm, input logic [25:0] tgt,
                                            output bit legal);
    int unsigned s = 32'(rs), t = 32'(rt), d = 32'(rd), i = 32'(imm), j = 32'(tgt);
    int unsigned w = 0;
    legal = 1'b1;
    case (int'(op))
      0: w = 0;
      1: w = s * 2097152 + t * 65536 + d * 2048 + 33;
      2: w = s * 2097152 + t * 65536 + d * 2048 + 35;
      3: w = 13 * 67108864 + s * 2097152 + t * 65536 + i;
      4: w = 35 * 67108864 + s * 2097152 + t * 65536 + i;
      5: w = 43 * 67108864 + s * 2097152 + t * 65536 + i;
      6: w = 4 * 67108864 + s * 2097152 + t * 65536 + i;
      7: w = 15 * 67108864 + t * 65536 + i;
      8: w = 3 * 67108864 + j;
      9: w = s * 2097152 + 8;
      default: legal = 1'b0;
    endcase
    return w;
  endfunction

  function automatic bit model_ready();
    return !reset && (m_q.size() < DEPTH) && (m_issued < IM);
  endfunction

  always @(posedge clk) begin
    bit          legal;
    bit          acc;
    bit          pop;
    logic [31:0] w;
    if (reset) begin
      m_q.delete();
      m_issued  = 0;
      m_written = 0;
      m_err     = 1'b0;
    end else begin
      acc = req_valid && (m_q.size() < DEPTH) && (m_issued < IM);
      pop = (m_q.size() > 0) && out_ready;
      w   = model_enc(req_op, req_rs, req_rt, req_rd, req_imm, req_target, legal);
      if (pop) begin
        void'(m_q.pop_front());
        m_written++;
      end
      if (acc) begin
        if (legal) begin
          m_q.push_back(w);
          m_issued++;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t log_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("req_ready", 32'(req_ready), 32'(model_ready()));
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("out_data", out_data, m_q[0]);
    check("out_addr", out_addr, BASE + 32'(4 * m_written));
    check("issued_cnt", 32'(issued_cnt), 32'(m_issued));
    check("written_cnt", 32'(written_cnt), 32'(m_written));
    check("err", 32'(err), 32'(m_err));
    check("done", 32'(done), 32'(m_written == IM));
    if (out_valid && out_ready && !reset) log_q.push_back('{addr: out_addr, data: out_data});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_target = tgt;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_out_data", out_data, 32'h0);
    check("rst_counts", 32'({issued_cnt, written_cnt}), 32'h0);
    check("rst_err_done", 32'({err, done}), 32'h0);
    log_q.delete();
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bit seen = 1'b0;
    set_req(op, rs, rt, rd, imm, tgt);
    req_valid = 1'b1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("send_accepted", 32'(seen), 32'h1);
  endtask

  task automatic wait_drain();
    bit busy = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && busy; k++) begin
      @(negedge clk);
      busy = out_valid;
    end
    check("drain_done", 32'(busy), 32'h0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] exp_seq [7];
    bit          lg;

    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none

    // Model pinned against hand-computed words
    check("pin_addu", model_enc(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, lg), 32'h0022_1821);
    check("pin_jr", model_enc(4'd9, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0, lg), 32'h03E0_0008);
    check("pin_lui", model_enc(4'd7, 5'd9, 5'd1, 5'd0, 16'hFFFF, 26'h0, lg), 32'h3C01_FFFF);
    void'(model_enc(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, lg));
    check("pin_illegal", 32'(lg), 32'h0);

    // Basic encode
    do_reset();
    out_ready = 1'b1;
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_data", out_data, 32'h0022_1821);
    check("basic_addr", out_addr, 32'h0000_3000);
    @(posedge clk); #1;
    check("basic_written", 32'(written_cnt), 32'h1);
    check("basic_log", 32'(log_q.size()), 32'h1);

    // Full sequence
    exp_seq = '{32'h3401_1234, 32'h8C04_0004, 32'hAC02_0008, 32'h1022_FFFF,
                32'h3C01_FFFF, 32'h0C00_0C00, 32'h03E0_0008};
    do_reset();
    out_ready = 1'b1;
    send(4'd3, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0);
    send(4'd4, 5'd0, 5'd4, 5'd0, 16'h0004, 26'h0);
    send(4'd5, 5'd0, 5'd2, 5'd0, 16'h0008, 26'h0);
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    send(4'd7, 5'd0, 5'd1, 5'd0, 16'hFFFF, 26'h0);
    send(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C00);
    send(4'd9, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0);
    wait_drain();
    check("seq_count", 32'(log_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < log_q.size(); i++) begin
      check("seq_data", log_q[i].data, exp_seq[i]);
      check("seq_addr", log_q[i].addr, BASE + 32'(4 * i));
    end

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(4'd3, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0);
    set_req(4'd3, 5'd0, 5'd1, 5'd0, 16'd5, 26'h0);
    req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready5", 32'(req_ready), 32'h0);
      check("bp_head_data", out_data, 32'h3401_0001);
      check("bp_head_addr", out_addr, 32'h0000_3000);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain();
    check("bp_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      check("bp_data", log_q[i].data, 32'h3401_0000 + 32'(i + 1));
      check("bp_addr", log_q[i].addr, BASE + 32'(4 * i));
    end

    // Illegal op then NOP
    do_reset();
    out_ready = 1'b1;
    send(4'd12, 5'd3, 5'd3, 5'd3, 16'h1111, 26'h0);
    send(4'd0, 5'd7, 5'd7, 5'd7, 16'h2222, 26'h0);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("ill_err", 32'(err), 32'h1);
    check("ill_issued", 32'(issued_cnt), 32'h1);
    check("ill_count", 32'(log_q.size()), 32'h1);
    if (log_q.size() > 0) begin
      check("ill_data", log_q[0].data, 32'h0);
      check("ill_addr", log_q[0].addr, 32'h0000_3000);
    end

    // Capacity
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < IM; i++) send(4'd3, 5'd2, 5'd3, 5'd0, 16'(i), 26'h0);
    set_req(4'd3, 5'd2, 5'd3, 5'd0, 16'hBEEF, 26'h0);
    req_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("cap_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain();
    check("cap_done", 32'(done), 32'h1);
    check("cap_issued", 32'(issued_cnt), 32'(IM));
    check("cap_count", 32'(log_q.size()), 32'(IM));
    if (log_q.size() == IM) check("cap_last_addr", log_q[IM-1].addr, 32'h0000_301C);

    // Reset mid-stream
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'd1, 5'd4, 5'd5, 5'(i), 16'h0, 26'h0);
    check("mid_queued", 32'(issued_cnt), 32'd3);
    do_reset();
    out_ready = 1'b1;
    send(4'd2, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0);
    wait_drain();
    check("mid_count", 32'(log_q.size()), 32'h1);
    if (log_q.size() > 0) begin
      check("mid_addr", log_q[0].addr, 32'h0000_3000);
      check("mid_data", log_q[0].data, 32'h0109_5023);
    end

    // Randomized traffic with occasional resets
    for (int r = 0; r < 15; r++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        reset     = ($urandom_range(0, 39) == 0);
        req_valid = $urandom_range(0, 1) == 1;
        out_ready = $urandom_range(0, 2) != 0;
        set_req(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                16'($urandom), 26'($urandom));
        @(posedge clk); #1;
      end
      reset = 1'b0;
      wait_drain();
    end

    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
